alarm_ringer: RTL and testbench

//  Annunciator stage downstream of the alarm-time comparator. Consumes flag_alarm / flag_alarm_armed.

---
 rtl/alarm_ringer_pkg.sv | 12 +
 rtl/alarm_ringer_btn_sync_edge.sv | 26 ++
 rtl/alarm_ringer.sv | 148 ++++++++++++++
 tb/tb_alarm_ringer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ringer_pkg.sv
// Shared state encoding and button idle level for the alarm annunciator blocks.
package alarm_ringer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam logic BTN_IDLE = 1'b1;

endpackage

// File: rtl/alarm_ringer_btn_sync_edge.sv
// Two-flop synchroniser for an active-low pushbutton with a one-cycle press pulse on the falling edge.
// press is valid the cycle after the first edge that samples the pin low; no backpressure.
module alarm_ringer_btn_sync_edge
  import alarm_ringer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic ff0, ff1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff0 <= BTN_IDLE;
      ff1 <= BTN_IDLE;
    end else begin
      ff0 <= btn;
      ff1 <= ff0;
    end
  end

  assign press = ff1 & ~ff0;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm annunciator: cadenced buzzer, LED, snooze/stop and ring timeout driven by the alarm comparator flag.
// Outputs registered one edge after the deciding input; no backpressure.
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TONE_HZ        = 2000,
  parameter int BEEP_HZ        = 2,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flag_alarm,
  input  logic                            flag_alarm_armed,
  input  logic                            btn_snooze,
  input  logic                            btn_stop,
  output logic                            buzzer,
  output logic                            led_alarm,
  output logic                            ringing,
  output logic                            snoozing,
  output logic [$clog2(SNOOZE_S+1)-1:0]   snooze_left
);

  localparam int RW       = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW       = $clog2(SNOOZE_S + 1);
  localparam int PW       = $clog2(CLK_HZ);
  localparam int TONE_DIV = CLK_HZ / (2 * TONE_HZ);
  localparam int CAD_DIV  = CLK_HZ / (2 * BEEP_HZ);
  localparam int TW       = $clog2(TONE_DIV + 1);
  localparam int CW       = $clog2(CAD_DIV + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [TW-1:0] TONE_MAX  = TW'(TONE_DIV - 1);
  localparam logic [CW-1:0] CAD_MAX   = CW'(CAD_DIV - 1);
  localparam logic [RW-1:0] RING_LOAD = RW'(RING_TIMEOUT_S);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S);

  state_t        state, state_nxt;
  logic          flag_q, stop_press, snz_press, rise, tick, entering;
  logic [PW-1:0] presc, presc_nxt;
  logic [RW-1:0] ring_cnt, ring_cnt_nxt;
  logic [SW-1:0] snz_cnt, snz_cnt_nxt;
  logic [TW-1:0] tone_cnt, tone_cnt_nxt;
  logic [CW-1:0] cad_cnt, cad_cnt_nxt;
  logic          tone, tone_nxt, cadence, cadence_nxt;

  alarm_ringer_btn_sync_edge u_stop (.clk(clk), .reset(reset), .btn(btn_stop),   .press(stop_press));
  alarm_ringer_btn_sync_edge u_snz  (.clk(clk), .reset(reset), .btn(btn_snooze), .press(snz_press));

  assign rise = flag_alarm & ~flag_q;
  assign tick = (state != ST_IDLE) && (presc == PRESC_MAX);

  always_comb begin
    state_nxt    = state;
    presc_nxt    = presc;
    ring_cnt_nxt = ring_cnt;
    snz_cnt_nxt  = snz_cnt;
    tone_cnt_nxt = tone_cnt;
    cad_cnt_nxt  = cad_cnt;
    tone_nxt     = tone;
    cadence_nxt  = cadence;

    case (state)
      ST_IDLE: begin
        if (rise && flag_alarm_armed) state_nxt = ST_RINGING;
      end
      ST_RINGING: begin
        if (!flag_alarm_armed || stop_press)       state_nxt = ST_IDLE;
        else if (snz_press)                        state_nxt = ST_SNOOZE;
        else if (tick && ring_cnt == RW'(1))       state_nxt = ST_IDLE;
      end
      ST_SNOOZE: begin
        if (!flag_alarm_armed || stop_press)       state_nxt = ST_IDLE;
        else if (rise || (tick && snz_cnt == SW'(1))) state_nxt = ST_RINGING;
      end
      default: state_nxt = ST_IDLE;
    endcase

    entering = (state_nxt != state);

    // Restarting the prescaler on entry keeps every duration an exact number of seconds.
    if (entering || state_nxt == ST_IDLE || tick) presc_nxt = '0;
    else                                          presc_nxt = presc + PW'(1);

    if (entering && state_nxt == ST_RINGING)  ring_cnt_nxt = RING_LOAD;
    else if (state == ST_RINGING && tick)     ring_cnt_nxt = ring_cnt - RW'(1);

    if (entering && state_nxt == ST_SNOOZE)   snz_cnt_nxt = SNZ_LOAD;
    else if (state == ST_SNOOZE && tick)      snz_cnt_nxt = snz_cnt - SW'(1);

    if (entering || state_nxt != ST_RINGING) begin
      tone_cnt_nxt = '0;
      tone_nxt     = 1'b0;
      cad_cnt_nxt  = '0;
      cadence_nxt  = 1'b1;
    end else begin
      if (tone_cnt == TONE_MAX) begin
        tone_cnt_nxt = '0;
        tone_nxt     = ~tone;
      end else begin
        tone_cnt_nxt = tone_cnt + TW'(1);
      end
      if (cad_cnt == CAD_MAX) begin
        cad_cnt_nxt = '0;
        cadence_nxt = ~cadence;
      end else begin
        cad_cnt_nxt = cad_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      flag_q      <= 1'b0;
      presc       <= '0;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      tone_cnt    <= '0;
      cad_cnt     <= '0;
      tone        <= 1'b0;
      cadence     <= 1'b1;
      buzzer      <= 1'b0;
      led_alarm   <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
      snooze_left <= '0;
    end else begin
      state       <= state_nxt;
      flag_q      <= flag_alarm;
      presc       <= presc_nxt;
      ring_cnt    <= ring_cnt_nxt;
      snz_cnt     <= snz_cnt_nxt;
      tone_cnt    <= tone_cnt_nxt;
      cad_cnt     <= cad_cnt_nxt;
      tone        <= tone_nxt;
      cadence     <= cadence_nxt;
      // Outputs come from next-state values so they line up with ringing/snoozing.
      buzzer      <= (state_nxt == ST_RINGING) & cadence_nxt & tone_nxt;
      led_alarm   <= (state_nxt == ST_RINGING) ? cadence_nxt : (state_nxt == ST_SNOOZE);
      ringing     <= (state_nxt == ST_RINGING);
      snoozing    <= (state_nxt == ST_SNOOZE);
      snooze_left <= (state_nxt == ST_SNOOZE) ? snz_cnt_nxt : '0;
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios plus random stimulus against a time-since-entry reference model.
module tb_alarm_ringer;

  localparam int CLK_HZ         = 20;
  localparam int TONE_HZ        = 5;
  localparam int BEEP_HZ        = 1;
  localparam int RING_TIMEOUT_S = 3;
  localparam int SNOOZE_S       = 2;
  localparam int SW             = $clog2(SNOOZE_S + 1);

  localparam int CAD_HALF = CLK_HZ / (2 * BEEP_HZ);
  localparam int TONE_HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int RING_CYC = RING_TIMEOUT_S * CLK_HZ;
  localparam int SNZ_CYC  = SNOOZE_S * CLK_HZ;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flag_alarm, flag_alarm_armed, btn_snooze, btn_stop;
  logic buzzer, led_alarm, ringing, snoozing;
  logic [SW-1:0] snooze_left;

  int n_cmp = 0;
  int n_err = 0;

  int m_mode, m_k;
  bit m_s1, m_s2, m_z1, m_z2, m_fprev;

  always #5 clk = ~clk;

  alarm_ringer #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .BEEP_HZ(BEEP_HZ),
    .RING_TIMEOUT_S(RING_TIMEOUT_S), .SNOOZE_S(SNOOZE_S)
  ) dut (
    .clk(clk), .reset(reset),
    .flag_alarm(flag_alarm), .flag_alarm_armed(flag_alarm_armed),
    .btn_snooze(btn_snooze), .btn_stop(btn_stop),
    .buzzer(buzzer), .led_alarm(led_alarm),
    .ringing(ringing), .snoozing(snoozing), .snooze_left(snooze_left)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_k = 0;
    m_s1 = 1; m_s2 = 1; m_z1 = 1; m_z2 = 1; m_fprev = 0;
  endtask

  // One clock edge of the reference: a press is a high-then-low pair of pin samples, the state
  // is tracked as a mode plus the number of edges spent in it.
  task automatic model_edge();
    bit ps, pz, rise;
    ps = m_s2 && !m_s1; m_s2 = m_s1; m_s1 = btn_stop;
    pz = m_z2 && !m_z1; m_z2 = m_z1; m_z1 = btn_snooze;
    rise = flag_alarm && !m_fprev; m_fprev = flag_alarm;
    case (m_mode)
      M_IDLE: if (rise && flag_alarm_armed) begin m_mode = M_RING; m_k = 0; end
      M_RING: begin
        if (!flag_alarm_armed || ps)   m_mode = M_IDLE;
        else if (pz)                   begin m_mode = M_SNZ; m_k = 0; end
        else if (m_k + 1 == RING_CYC)  m_mode = M_IDLE;
        else                           m_k++;
      end
      default: begin
        if (!flag_alarm_armed || ps)             m_mode = M_IDLE;
        else if (rise || m_k + 1 == SNZ_CYC)     begin m_mode = M_RING; m_k = 0; end
        else                                     m_k++;
      end
    endcase
  endtask

  task automatic compare_model();
    int e_ring, e_snz, cad_on, tone_on;
    e_ring  = (m_mode == M_RING) ? 1 : 0;
    e_snz   = (m_mode == M_SNZ) ? 1 : 0;
    cad_on  = (((m_k / CAD_HALF) % 2) == 0) ? 1 : 0;
    tone_on = (((m_k / TONE_HALF) % 2) == 1) ? 1 : 0;
    check_val("ringing",     int'(ringing),     e_ring);
    check_val("snoozing",    int'(snoozing),    e_snz);
    check_val("buzzer",      int'(buzzer),      e_ring & cad_on & tone_on);
    check_val("led_alarm",   int'(led_alarm),   e_ring ? cad_on : e_snz);
    check_val("snooze_left", int'(snooze_left), e_snz ? SNOOZE_S - m_k / CLK_HZ : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_ringing"},  int'(ringing),     0);
    check_val({tag, "_snoozing"}, int'(snoozing),    0);
    check_val({tag, "_buzzer"},   int'(buzzer),      0);
    check_val({tag, "_led"},      int'(led_alarm),   0);
    check_val({tag, "_left"},     int'(snooze_left), 0);
  endtask

  // Entered just after a falling clock edge; asserts reset between edges.
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_zero(tag);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_zero({tag, "_held"});
    end
    reset = 1'b1;
  endtask

  initial begin
    flag_alarm = 1; flag_alarm_armed = 0; btn_stop = 0; btn_snooze = 0;
    do_reset("rst");

    // Level already high at release never rings without a fresh rise.
    repeat (3) step();
    btn_stop = 1; btn_snooze = 1; flag_alarm_armed = 1;
    repeat (3) step();
    check_val("no_ring_after_rst", int'(ringing), 0);
    flag_alarm = 0; step();
    flag_alarm = 1; step();
    check_val("ring_on_rise", int'(ringing), 1);
    flag_alarm = 0;
    repeat (RING_CYC - 1) step();
    check_val("ring_before_timeout", int'(ringing), 1);
    step();
    check_val("ring_timeout", int'(ringing), 0);

    // Unarmed flag is ignored.
    flag_alarm_armed = 0; flag_alarm = 1;
    repeat (20) step();
    check_val("unarmed_led", int'(led_alarm), 0);
    flag_alarm = 0; step();
    flag_alarm_armed = 1; step();

    // Snooze, count down, re-ring.
    flag_alarm = 1; step();
    flag_alarm = 0;
    repeat (3) step();
    btn_snooze = 0; step(); step();
    check_val("snooze_entry", int'(snoozing), 1);
    check_val("snooze_left_init", int'(snooze_left), SNOOZE_S);
    btn_snooze = 1;
    repeat (CLK_HZ - 1) step();
    check_val("snooze_left_hold", int'(snooze_left), SNOOZE_S);
    step();
    check_val("snooze_left_dec", int'(snooze_left), SNOOZE_S - 1);
    repeat (CLK_HZ - 1) step();
    check_val("snooze_before_expire", int'(snoozing), 1);
    step();
    check_val("snooze_expire_ring", int'(ringing), 1);

    // Stop beats snooze; stop from SNOOZE.
    repeat (2) step();
    btn_stop = 0; btn_snooze = 0; step(); step();
    check_val("stop_wins_ring", int'(ringing), 0);
    check_val("stop_wins_snz", int'(snoozing), 0);
    btn_stop = 1; btn_snooze = 1;
    repeat (3) step();
    flag_alarm = 1; step();
    flag_alarm = 0; step();
    btn_snooze = 0; step(); step();
    btn_snooze = 1;
    repeat (3) step();
    btn_stop = 0; step(); step();
    check_val("snz_stop_idle", int'(snoozing), 0);
    check_val("snz_stop_left", int'(snooze_left), 0);
    btn_stop = 1;
    repeat (2) step();

    // Held flag with stop at cycle 5, then async reset while the buzzer is on.
    flag_alarm = 1; step();
    repeat (4) step();
    btn_stop = 0; step(); step();
    btn_stop = 1;
    repeat (23) step();
    check_val("held_flag_no_retrig", int'(ringing), 0);
    flag_alarm = 0; step();
    flag_alarm = 1; step();
    flag_alarm = 0; step(); step();
    check_val("pre_rst_buzzer", int'(buzzer), 1);
    do_reset("async_rst");

    // Random traffic.
    flag_alarm_armed = 1; btn_stop = 1; btn_snooze = 1; flag_alarm = 0;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0)  btn_stop = ~btn_stop;
      if ($urandom_range(0, 29) == 0)  btn_snooze = ~btn_snooze;
      if ($urandom_range(0, 49) == 0)  flag_alarm = ~flag_alarm;
      if ($urandom_range(0, 199) == 0) flag_alarm_armed = ~flag_alarm_armed;
      else if (!flag_alarm_armed && $urandom_range(0, 4) == 0) flag_alarm_armed = 1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
